// File: rtl/mem_read_arbiter.sv
// Two-port round-robin arbiter that shares one memory read channel between
// instruction fetch and the load unit, allowing a single outstanding read.
module mem_read_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            i_im_arvalid,
    output logic            o_im_arready,
    input  logic [XLEN-1:0] i_im_araddr,
    input  logic [2:0]      i_im_arprot,
    output logic            o_im_rvalid,
    input  logic            i_im_rready,
    output logic [XLEN-1:0] o_im_rdata,
    output logic [1:0]      o_im_rresp,

    input  logic            i_dm_arvalid,
    output logic            o_dm_arready,
    input  logic [XLEN-1:0] i_dm_araddr,
    input  logic [2:0]      i_dm_arprot,
    output logic            o_dm_rvalid,
    input  logic            i_dm_rready,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic [1:0]      o_dm_rresp,

    output logic            o_mem_arvalid,
    input  logic            i_mem_arready,
    output logic [XLEN-1:0] o_mem_araddr,
    output logic [2:0]      o_mem_arprot,
    input  logic            i_mem_rvalid,
    output logic            o_mem_rready,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic [1:0]      i_mem_rresp,

    output logic [1:0]      o_grant
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            owner_dm;
    logic            last_dm;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      prot_q;
    logic            grant_im;
    logic            grant_dm;
    logic            owner_rready;

    // Data wins a contest unless it was the previous winner.
    assign grant_dm     = i_dm_arvalid & (~i_im_arvalid | ~last_dm);
    assign grant_im     = i_im_arvalid & ~grant_dm;
    assign owner_rready = owner_dm ? i_dm_rready : i_im_rready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            owner_dm <= 1'b0;
            last_dm  <= 1'b0;
            addr_q   <= '0;
            prot_q   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (grant_im || grant_dm)) begin
                owner_dm <= grant_dm;
                last_dm  <= grant_dm;
                addr_q   <= grant_dm ? i_dm_araddr : i_im_araddr;
                prot_q   <= grant_dm ? i_dm_arprot : i_im_arprot;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_im || grant_dm) state_next = ADDR;
            ADDR: if (i_mem_arready) state_next = DATA;
            DATA: if (i_mem_rvalid && owner_rready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arready is gated by rstn so nothing is accepted while reset is held.
    always_comb begin
        o_im_arready  = 1'b0;
        o_dm_arready  = 1'b0;
        o_mem_arvalid = 1'b0;
        o_mem_rready  = 1'b0;
        o_im_rvalid   = 1'b0;
        o_dm_rvalid   = 1'b0;
        o_grant       = 2'b00;
        case (state)
            IDLE: begin
                o_im_arready = grant_im & rstn;
                o_dm_arready = grant_dm & rstn;
            end
            ADDR: begin
                o_mem_arvalid = 1'b1;
                o_grant       = owner_dm ? 2'b10 : 2'b01;
            end
            DATA: begin
                o_mem_rready = owner_rready;
                o_im_rvalid  = i_mem_rvalid & ~owner_dm;
                o_dm_rvalid  = i_mem_rvalid & owner_dm;
                o_grant      = owner_dm ? 2'b10 : 2'b01;
            end
            default: begin
                o_grant = 2'b00;
            end
        endcase
    end

    assign o_mem_araddr = addr_q;
    assign o_mem_arprot = prot_q;
    assign o_im_rdata   = i_mem_rdata;
    assign o_im_rresp   = i_mem_rresp;
    assign o_dm_rdata   = i_mem_rdata;
    assign o_dm_rresp   = i_mem_rresp;

endmodule
